mem_access_controller: RTL

- Parametrised successor to the single-byte cache/memory controller between the CPU load/store unit, an external lookup cache and a beat-based memory port.
- Serves byte/half/word (and double when XLEN=64) loads and stores over a memory bus of MEM_BYTES bytes per beat, with byte enables.
- Adds sign/zero extension, misalignment and timeout error reporting, and split memory data buses.

---
 rtl/mem_access_pkg.sv | 66 ++++++
 rtl/mem_access_controller_beat_port.sv | 142 ++++++++++++++
 rtl/mem_access_controller.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared types and helpers for the memory access controller:
//               access size codes, controller state encoding, access byte
//               count, load-result extension and lane byte-enable mask.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_MREAD  = 3'd2,
        ST_MCAPT  = 3'd3,
        ST_FILL   = 3'd4,
        ST_MWRITE = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    // Number of bytes touched by an access of size code lim (1, 2, 4 or 8).
    function automatic logic [3:0] bytes_of(input logic [1:0] lim);
        return 4'd1 << lim;
    endfunction

    // Keep the low 2^lim bytes of data and fill the rest with zeros, or with
    // copies of the access's top bit when sgn is set.
    function automatic logic [63:0] extend(input logic [63:0] data,
                                           input logic [1:0]  lim,
                                           input logic        sgn);
        logic [63:0] r;
        case (lim)
            SZ_B:    r = {{56{sgn & data[7]}},  data[7:0]};
            SZ_H:    r = {{48{sgn & data[15]}}, data[15:0]};
            SZ_W:    r = {{32{sgn & data[31]}}, data[31:0]};
            default: r = data;
        endcase
        return r;
    endfunction

    // Byte enables for one beat of a bus mem_bytes wide. Accesses at least
    // as wide as the bus enable every lane; narrower ones enable their own
    // bytes starting at the lane the address falls in.
    function automatic logic [7:0] lane_mask(input logic [2:0] addr_lo,
                                             input logic [1:0] lim,
                                             input logic [3:0] mem_bytes);
        logic [3:0] n;
        logic [2:0] lane;
        logic [7:0] full;
        logic [7:0] part;
        n    = bytes_of(lim);
        lane = addr_lo & 3'(mem_bytes - 4'd1);
        full = 8'hFF >> (4'd8 - mem_bytes);
        part = 8'hFF >> (4'd8 - n);
        return (n >= mem_bytes) ? full : (part << lane);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_controller_beat_port.sv
`default_nettype none
// ============================================================================
// Module      : mem_beat_port
// Description : Beat sequencer for the memory port. Holds MRE/MWE, MADDR,
//               MBE and the MDOUT slice stable until MRDY, counts beats,
//               and times out a beat that waits TIMEOUT cycles for MRDY.
// Ports       : i_start/i_write/i_addr/i_lim/i_wdata  - begin an access
//               i_next                                - issue next read beat
//               i_mrdy/i_mdin                         - memory handshake/data
//               o_mre/o_mwe/o_maddr/o_mbe/o_mdout     - memory request
//               o_rdata  - read lanes shifted down to byte 0
//               o_beat/o_last/o_accept/o_timeout      - sequencing status
// Revision    : 1.0 - initial release
// ============================================================================
module mem_beat_port
    import mem_access_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_write,
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic [1:0]             i_lim,
    input  logic [XLEN-1:0]        i_wdata,
    input  logic                   i_next,
    input  logic                   i_mrdy,
    input  logic [8*MEM_BYTES-1:0] i_mdin,
    output logic                   o_mre,
    output logic                   o_mwe,
    output logic [ADDR_W-1:0]      o_maddr,
    output logic [MEM_BYTES-1:0]   o_mbe,
    output logic [8*MEM_BYTES-1:0] o_mdout,
    output logic [8*MEM_BYTES-1:0] o_rdata,
    output logic [3:0]             o_beat,
    output logic                   o_last,
    output logic                   o_accept,
    output logic                   o_timeout
);

    localparam int MW    = 8 * MEM_BYTES;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic                 r_mre;
    logic                 r_mwe;
    logic [ADDR_W-1:0]    r_maddr;
    logic [MEM_BYTES-1:0] r_mbe;
    logic [MW-1:0]        r_mdout;
    logic [XLEN-1:0]      r_wdata;
    logic [2:0]           r_lane;
    logic [3:0]           r_beat;
    logic [3:0]           r_nbeats;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_strobe;
    logic [3:0]           w_n;
    logic [3:0]           w_nbeats;
    logic [2:0]           w_lane;
    logic [ADDR_W-1:0]    w_base;
    logic [MEM_BYTES-1:0] w_mask;
    logic [MW-1:0]        w_wd0;

    assign w_strobe  = r_mre | r_mwe;
    assign o_accept  = w_strobe & i_mrdy;
    assign o_timeout = w_strobe & ~i_mrdy & (r_cnt == CNT_W'(TIMEOUT - 1));
    assign o_last    = (r_beat == (r_nbeats - 4'd1));
    assign o_beat    = r_beat;
    assign o_rdata   = i_mdin >> {r_lane, 3'b000};

    // Sub-beat accesses use the lane-aligned base and a shifted lane; wider
    // accesses are aligned by construction so the lane is always zero.
    assign w_n      = bytes_of(i_lim);
    assign w_nbeats = (w_n > 4'(MEM_BYTES)) ? (w_n / 4'(MEM_BYTES)) : 4'd1;
    assign w_lane   = i_addr[2:0] & 3'(MEM_BYTES - 1);
    assign w_base   = i_addr & ~ADDR_W'(MEM_BYTES - 1);
    assign w_mask   = MEM_BYTES'(lane_mask(i_addr[2:0], i_lim, 4'(MEM_BYTES)));
    assign w_wd0    = MW'(i_wdata) << {w_lane, 3'b000};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mre    <= 1'b0;
            r_mwe    <= 1'b0;
            r_maddr  <= '0;
            r_mbe    <= '0;
            r_mdout  <= '0;
            r_wdata  <= '0;
            r_lane   <= '0;
            r_beat   <= '0;
            r_nbeats <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_mre    <= ~i_write;
            r_mwe    <= i_write;
            r_maddr  <= w_base;
            r_mbe    <= w_mask;
            r_mdout  <= i_write ? w_wd0 : '0;
            r_wdata  <= i_wdata;
            r_lane   <= w_lane;
            r_beat   <= 4'd0;
            r_nbeats <= w_nbeats;
            r_cnt    <= '0;
        end else if (i_next) begin
            r_mre   <= 1'b1;
            r_maddr <= r_maddr + ADDR_W'(MEM_BYTES);
            r_beat  <= r_beat + 4'd1;
            r_cnt   <= '0;
        end else if (o_accept) begin
            r_cnt <= '0;
            if (r_mwe && !o_last) begin
                // Store beats run back to back: the next slice goes out
                // on the cycle after the previous one was accepted.
                r_maddr <= r_maddr + ADDR_W'(MEM_BYTES);
                r_mdout <= MW'(r_wdata >> MW);
                r_wdata <= r_wdata >> MW;
                r_beat  <= r_beat + 4'd1;
            end else begin
                // Reads keep the beat index so the capture lands in the
                // right slot; the controller asks for the next beat.
                r_mre <= 1'b0;
                r_mwe <= 1'b0;
            end
        end else if (o_timeout) begin
            r_mre <= 1'b0;
            r_mwe <= 1'b0;
            r_cnt <= '0;
        end else if (w_strobe) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_mre   = r_mre;
    assign o_mwe   = r_mwe;
    assign o_maddr = r_maddr;
    assign o_mbe   = r_mbe;
    assign o_mdout = r_mdout;

endmodule
`default_nettype wire

// File: rtl/mem_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_controller
// Description : Load/store controller between the CPU LSU, a lookup cache
//               and a beat-based memory port. Loads try the cache first and
//               fill it on a miss; stores write through to cache and memory.
// Ports       : i_we/i_rreq/i_addr/i_din/i_lim/i_signed - CPU request
//               o_busy/o_rdy/o_err/o_dout                - CPU response
//               i_found/i_cdout/o_cdin/o_cwe             - cache interface
//               o_maddr/o_mre/o_mwe/o_mbe/o_mdout/i_mdin/i_mrdy - memory
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_controller
    import mem_access_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_we,
    input  logic                   i_rreq,
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic [XLEN-1:0]        i_din,
    input  logic [1:0]             i_lim,
    input  logic                   i_signed,
    output logic                   o_busy,
    output logic                   o_rdy,
    output logic                   o_err,
    output logic [XLEN-1:0]        o_dout,
    input  logic                   i_found,
    input  logic [XLEN-1:0]        i_cdout,
    output logic [XLEN+2:0]        o_cdin,
    output logic                   o_cwe,
    output logic [ADDR_W-1:0]      o_maddr,
    output logic                   o_mre,
    output logic                   o_mwe,
    output logic [MEM_BYTES-1:0]   o_mbe,
    output logic [8*MEM_BYTES-1:0] o_mdout,
    input  logic [8*MEM_BYTES-1:0] i_mdin,
    input  logic                   i_mrdy
);

    localparam int MW = 8 * MEM_BYTES;

    state_e            r_state;
    logic              r_busy;
    logic              r_rdy;
    logic              r_err;
    logic              r_cwe;
    logic [XLEN+2:0]   r_cdin;
    logic [XLEN-1:0]   r_dout;
    logic [XLEN-1:0]   r_buf;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_lim;
    logic              r_signed;

    logic              w_illegal;
    logic [3:0]        w_n;
    logic [XLEN-1:0]   w_din_masked;
    logic [XLEN-1:0]   w_ext;
    logic              w_start;
    logic              w_start_wr;
    logic [ADDR_W-1:0] w_p_addr;
    logic [1:0]        w_p_lim;
    logic              w_next;
    logic [MW-1:0]     w_rdata;
    logic [3:0]        w_beat;
    logic [6:0]        w_cap_sh;
    logic              w_last;
    logic              w_accept;
    logic              w_timeout;

    assign w_n          = bytes_of(i_lim);
    assign w_illegal    = (|(i_addr[3:0] & (w_n - 4'd1))) ||
                          ((i_lim == SZ_D) && (XLEN == 32));
    assign w_din_masked = XLEN'(extend(64'(i_din), i_lim, 1'b0));
    assign w_ext        = XLEN'(extend(64'(r_buf), r_lim, r_signed));

    // Stores start the memory port straight from IDLE using the live request;
    // loads start it from LOOKUP on a miss using the latched request.
    assign w_start_wr = (r_state == ST_IDLE);
    assign w_start    = ((r_state == ST_IDLE) && i_we && !w_illegal) ||
                        ((r_state == ST_LOOKUP) && !i_found);
    assign w_p_addr   = w_start_wr ? i_addr : r_addr;
    assign w_p_lim    = w_start_wr ? i_lim : r_lim;
    assign w_next     = (r_state == ST_MCAPT) && !w_last;
    assign w_cap_sh   = 7'(w_beat) * 7'(MW);

    mem_beat_port #(
        .XLEN      (XLEN),
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES),
        .TIMEOUT   (TIMEOUT)
    ) u_beat_port (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (w_start),
        .i_write   (w_start_wr),
        .i_addr    (w_p_addr),
        .i_lim     (w_p_lim),
        .i_wdata   (w_din_masked),
        .i_next    (w_next),
        .i_mrdy    (i_mrdy),
        .i_mdin    (i_mdin),
        .o_mre     (o_mre),
        .o_mwe     (o_mwe),
        .o_maddr   (o_maddr),
        .o_mbe     (o_mbe),
        .o_mdout   (o_mdout),
        .o_rdata   (w_rdata),
        .o_beat    (w_beat),
        .o_last    (w_last),
        .o_accept  (w_accept),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_rdy    <= 1'b0;
            r_err    <= 1'b0;
            r_cwe    <= 1'b0;
            r_cdin   <= '0;
            r_dout   <= '0;
            r_buf    <= '0;
            r_addr   <= '0;
            r_lim    <= '0;
            r_signed <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            r_err <= 1'b0;
            r_cwe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_we || i_rreq) begin
                        r_busy   <= 1'b1;
                        r_addr   <= i_addr;
                        r_lim    <= i_lim;
                        r_signed <= i_signed;
                        if (w_illegal) begin
                            r_state <= ST_DONE;
                            r_rdy   <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (i_we) begin
                            // Write-through: the cache sees the store at once.
                            r_state <= ST_MWRITE;
                            r_cwe   <= 1'b1;
                            r_cdin  <= {i_signed, i_lim, w_din_masked};
                        end else begin
                            r_state <= ST_LOOKUP;
                            r_cdin  <= {i_signed, i_lim, {XLEN{1'b0}}};
                            r_buf   <= '0;
                        end
                    end
                end
                ST_LOOKUP: begin
                    if (i_found) begin
                        r_dout  <= i_cdout;
                        r_state <= ST_DONE;
                        r_rdy   <= 1'b1;
                    end else begin
                        r_state <= ST_MREAD;
                    end
                end
                ST_MREAD: begin
                    if (w_accept) begin
                        r_state <= ST_MCAPT;
                    end else if (w_timeout) begin
                        r_state <= ST_DONE;
                        r_rdy   <= 1'b1;
                        r_err   <= 1'b1;
                    end
                end
                ST_MCAPT: begin
                    // Read data arrives the cycle after MRDY.
                    r_buf   <= r_buf | (XLEN'(w_rdata) << w_cap_sh);
                    r_state <= w_last ? ST_FILL : ST_MREAD;
                end
                ST_FILL: begin
                    r_dout  <= w_ext;
                    r_cwe   <= 1'b1;
                    r_cdin  <= {r_signed, r_lim, w_ext};
                    r_state <= ST_DONE;
                    r_rdy   <= 1'b1;
                end
                ST_MWRITE: begin
                    if (w_accept && w_last) begin
                        r_state <= ST_DONE;
                        r_rdy   <= 1'b1;
                    end else if (w_timeout) begin
                        r_state <= ST_DONE;
                        r_rdy   <= 1'b1;
                        r_err   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_rdy  = r_rdy;
    assign o_err  = r_err;
    assign o_cwe  = r_cwe;
    assign o_cdin = r_cdin;
    assign o_dout = r_dout;

endmodule
`default_nettype wire
